systolic_feeder: RTL and testbench

- Input-side stage for the systolic array, directly downstream of the activation buffer and alongside the `scheduler`.
- Stores one MATRIX_SIZE×MATRIX_SIZE block of activation vectors, then streams it into the array rows with a diagonal skew: lane i is delayed by i steps.
- Advances one step every STEP_CYCLES cycles, so its (2·MATRIX_SIZE−1)-step window matches the scheduler's row-enable cadence.
- Pulses `done` when the last lane has drained.

---
 rtl/systolic_feeder.sv | 110 +++++++++++
 tb/tb_systolic_feeder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers an NxN activation block and streams it diagonally skewed into the array rows.
// Optional FEEDER_ZERO_PAD_EN: start accepted with a partial block, missing vectors streamed as valid zeros.
module systolic_feeder #(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE = 32,
  parameter int STEP_CYCLES = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              general_enable,
  input  logic                              start,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [MATRIX_SIZE*DATA_SIZE-1:0]  in_data,
  output logic [$clog2(MATRIX_SIZE+1)-1:0]  fill,
  output logic                              busy,
  output logic [MATRIX_SIZE*DATA_SIZE-1:0]  a_data,
  output logic [MATRIX_SIZE-1:0]            a_valid,
  output logic                              done
);
  localparam int N = MATRIX_SIZE;
  localparam int FW = $clog2(N + 1);
  localparam int KW = $clog2(2 * N);
  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;
  state_t state_q, state_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [KW-1:0] k_q, k_d, k_step;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N*DATA_SIZE-1:0] a_data_q, a_data_d;
  logic [N-1:0] a_valid_q, a_valid_d;
  logic done_q, done_d;
  logic [N*DATA_SIZE-1:0] mem_q [N];
  logic full, start_ok, push, wrap, running, start_acc, step, finish;
  assign full = fill_q == FW'(N);
`ifdef FEEDER_ZERO_PAD_EN
  assign start_ok = 1'b1;
`else
  assign start_ok = full;
`endif
  assign running = state_q != IDLE;
  assign in_ready = general_enable & ~reset & ~running & ~full & ~start;
  assign push = in_valid & in_ready;
  assign wrap = cnt_q == CW'(STEP_CYCLES - 1);
  assign start_acc = general_enable & ~running & start & start_ok;
  assign finish = general_enable & running & wrap & (k_q == KW'(2 * N - 2));
  assign step = start_acc | (general_enable & running & wrap & ~finish);
  assign k_step = start_acc ? '0 : k_q + KW'(1);
  // Lane i at step k shows slot k-i; slots at or beyond fill are zero-padded.
  always_comb begin
    state_d = state_q;
    fill_d = fill_q;
    k_d = k_q;
    cnt_d = cnt_q;
    a_data_d = a_data_q;
    a_valid_d = a_valid_q;
    done_d = general_enable ? 1'b0 : done_q;
    if (push) fill_d = fill_q + FW'(1);
    if (general_enable && running) cnt_d = wrap ? '0 : cnt_q + CW'(1);
    if (start_acc) cnt_d = '0;
    if (step) begin
      k_d = k_step;
      state_d = (k_step >= KW'(N - 1)) ? DRAIN : FEED;
      for (int i = 0; i < N; i++) begin
        a_valid_d[i] = 1'b0;
        a_data_d[i*DATA_SIZE +: DATA_SIZE] = '0;
        for (int s = 0; s < N; s++)
          if (int'(k_step) == s + i) begin
            a_valid_d[i] = 1'b1;
            a_data_d[i*DATA_SIZE +: DATA_SIZE] = (s < int'(fill_q)) ? mem_q[s][i*DATA_SIZE +: DATA_SIZE] : '0;
          end
      end
    end
    if (finish) begin
      state_d = IDLE;
      fill_d = '0;
      k_d = '0;
      a_data_d = '0;
      a_valid_d = '0;
      done_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fill_q <= '0;
      k_q <= '0;
      cnt_q <= '0;
      a_data_q <= '0;
      a_valid_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q <= fill_d;
      k_q <= k_d;
      cnt_q <= cnt_d;
      a_data_q <= a_data_d;
      a_valid_q <= a_valid_d;
      done_q <= done_d;
    end
  end
  always_ff @(posedge clk)
    for (int s = 0; s < N; s++)
      if (push && fill_q == FW'(s)) mem_q[s] <= in_data;
  assign fill = fill_q;
  assign busy = running;
  assign a_data = a_data_q;
  assign a_valid = a_valid_q;
  assign done = done_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed table, corner sequences and random traffic against a timing-formula model.
module tb_systolic_feeder;
  localparam int N = 2;
  localparam int S = 4;
  localparam int D = 32;
`ifdef FEEDER_ZERO_PAD_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif
  localparam logic [63:0] V0 = 64'h00000012_00000011;
  localparam logic [63:0] V1 = 64'h00000022_00000021;
  logic clk = 1'b0, reset, general_enable, start, in_valid, in_ready, busy, done;
  logic [N*D-1:0] in_data, a_data;
  logic [1:0] fill;
  logic [N-1:0] a_valid;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  systolic_feeder #(.MATRIX_SIZE(N), .DATA_SIZE(D), .STEP_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .general_enable(general_enable), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .fill(fill),
    .busy(busy), .a_data(a_data), .a_valid(a_valid), .done(done)
  );
  typedef struct {
    logic r, g, s, v;
    logic [63:0] d;
    logic rdy;
    logic [1:0] fill;
    logic busy;
    logic [1:0] val;
    logic [31:0] l0, l1;
    logic done;
  } row_t;
  row_t tbl[22];
  logic [63:0] mvec[N];
  int mfill = 0, mt = 0;
  bit mrun = 0, mdone = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  function automatic bit model_ready(input logic r, g, s);
    return g && !r && !mrun && mfill < N && !s;
  endfunction
  task automatic compare_model();
    logic [63:0] ed = '0;
    logic [1:0] ev = '0;
    if (mrun)
      for (int i = 0; i < N; i++) begin
        int k = mt / S - i;
        if (k >= 0 && k < N) begin
          ev[i] = 1'b1;
          ed[i*D +: D] = (k < mfill) ? mvec[k][i*D +: D] : '0;
        end
      end
    check("in_ready", 64'(in_ready), 64'(model_ready(reset, general_enable, start)));
    check("fill", 64'(fill), 64'(mfill));
    check("busy", 64'(busy), 64'(mrun));
    check("done", 64'(done), 64'(mdone));
    check("a_valid", 64'(a_valid), 64'(ev));
    check("a_data", a_data, ed);
  endtask
  task automatic model_edge(input logic r, g, s, v, input logic [63:0] d);
    bit rdy = model_ready(r, g, s);
    if (r) begin
      mrun = 0; mt = 0; mfill = 0; mdone = 0;
    end else if (g) begin
      mdone = 0;
      if (mrun) begin
        mt++;
        if (mt == (2 * N - 1) * S) begin
          mrun = 0; mdone = 1; mfill = 0;
        end
      end else if (s && (ZP || mfill == N)) begin
        mrun = 1; mt = 0;
      end else if (v && rdy) begin
        mvec[mfill] = d;
        mfill++;
      end
    end
  endtask
  task automatic step(input logic r, g, s, v, input logic [63:0] d);
    reset = r; general_enable = g; start = s; in_valid = v; in_data = d;
    #1;
    compare_model();
    @(posedge clk);
    model_edge(r, g, s, v, d);
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
  endtask
  task automatic wait_done(input string name, input int c0, input int exp);
    int c = c0;
    while (!done && c < 60) begin
      idle(1);
      c++;
    end
    check(name, 64'(c), 64'(exp));
  endtask
  initial begin
    tbl[0] = '{1, 1, 1, 1, V0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 1, 1, 1, V0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 1, 0, 0, '0, 1, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 1, 0, 1, V0, 1, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{0, 1, 0, 1, V1, 1, 1, 0, 0, 0, 0, 0};
    tbl[5] = '{0, 1, 0, 1, 64'hdead, 0, 2, 0, 0, 0, 0, 0};
    tbl[6] = '{0, 1, 0, 1, 64'hbeef, 0, 2, 0, 0, 0, 0, 0};
    tbl[7] = '{0, 1, 1, 0, '0, 0, 2, 0, 0, 0, 0, 0};
    for (int i = 8; i < 12; i++) tbl[i] = '{0, 1, 0, 0, '0, 0, 2, 1, 2'b01, 32'h11, 0, 0};
    for (int i = 12; i < 16; i++) tbl[i] = '{0, 1, 0, 0, '0, 0, 2, 1, 2'b11, 32'h21, 32'h12, 0};
    for (int i = 16; i < 20; i++) tbl[i] = '{0, 1, 0, 0, '0, 0, 2, 1, 2'b10, 0, 32'h22, 0};
    tbl[20] = '{0, 1, 0, 0, '0, 1, 0, 0, 0, 0, 0, 1};
    tbl[21] = '{0, 1, 0, 0, '0, 1, 0, 0, 0, 0, 0, 0};
    reset = 1; general_enable = 1; start = 1; in_valid = 1; in_data = V0;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      reset = tbl[i].r; general_enable = tbl[i].g; start = tbl[i].s;
      in_valid = tbl[i].v; in_data = tbl[i].d;
      #1;
      check($sformatf("tbl%0d_ready", i), 64'(in_ready), 64'(tbl[i].rdy));
      check($sformatf("tbl%0d_fill", i), 64'(fill), 64'(tbl[i].fill));
      check($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].busy));
      check($sformatf("tbl%0d_valid", i), 64'(a_valid), 64'(tbl[i].val));
      check($sformatf("tbl%0d_lane0", i), 64'(a_data[31:0]), 64'(tbl[i].l0));
      check($sformatf("tbl%0d_lane1", i), 64'(a_data[63:32]), 64'(tbl[i].l1));
      check($sformatf("tbl%0d_done", i), 64'(done), 64'(tbl[i].done));
      @(posedge clk);
      @(negedge clk);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b1, V0);
    step(1'b0, 1'b1, 1'b1, 1'b1, V1);
    check("early_fill", 64'(fill), 64'(1));
    check("early_busy", 64'(busy), 64'(ZP));
    if (ZP) begin
      wait_done("early_done_cycle", 1, 13);
      step(1'b0, 1'b1, 1'b0, 1'b1, V0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b1, V1);
    step(1'b0, 1'b1, 1'b1, 1'b0, '0);
    idle(5);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    wait_done("stall_done_cycle", 9, 16);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 1'b1, V0);
    step(1'b0, 1'b1, 1'b0, 1'b1, V1);
    step(1'b0, 1'b1, 1'b1, 1'b0, '0);
    idle(6);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    check("midrst_valid", 64'(a_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_fill", 64'(fill), 64'(0));
    idle(20);
    step(1'b0, 1'b1, 1'b0, 1'b1, V0);
    step(1'b0, 1'b1, 1'b0, 1'b1, V1);
    step(1'b0, 1'b1, 1'b1, 1'b0, '0);
    wait_done("postrst_done_cycle", 1, 13);
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 149) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0,
           1'($urandom_range(0, 1)), {$urandom, $urandom});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
